// File: rtl/arx_conv2d_reset_pkg.sv
// Shared encodings and widths for the conv2d reset sequencer.
package arx_conv2d_reset_pkg;

   localparam int STATE_W = 3;
   localparam int LLC_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      S_ASSERT    = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_REL_DRAM  = 3'd2,
      S_REL_SYS   = 3'd3,
      S_RUN       = 3'd4
   } seq_state_t;

endpackage

// File: rtl/arx_conv2d_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module arx_conv2d_bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/arx_conv2d_reset_sequencer.sv
// Staged reset release (DRAM first, then system) gated on a stable PLL lock,
// with re-assertion on lock loss or software request.
//
// state       | meaning
// S_ASSERT    | both resets held low for the minimum hold time
// S_WAIT_LOCK | both resets low, waiting for a continuous run of lock
// S_REL_DRAM  | DRAM reset released, system still held
// S_REL_SYS   | both resets released, one settling cycle
// S_RUN       | sequence complete, seq_done high
module arx_conv2d_reset_sequencer
   import arx_conv2d_reset_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES  = 8,
   parameter int unsigned LOCK_STABLE_CYCLES = 16,
   parameter int unsigned STAGE_GAP_CYCLES   = 4,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned CNT_WIDTH          = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               soft_rst_req,
   output logic               rstnn_dram,
   output logic               rstnn_system,
   output logic               seq_done,
   output logic [STATE_W-1:0] seq_state,
   output logic [LLC_W-1:0]   lock_loss_count
);

   localparam logic [CNT_WIDTH-1:0] HOLD_TC   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STABLE_TC = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_TC    = CNT_WIDTH'(STAGE_GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [LLC_W-1:0]     LLC_ONE   = LLC_W'(1);

   logic                 lock_s;
   seq_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [LLC_W-1:0]     llc_q, llc_d;
   logic                 lock_abort;
   logic                 dram_d, sys_d, done_d;
   logic                 dram_q, sys_q, done_q;

   arx_conv2d_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_ASSERT;
         cnt_q   <= '0;
         llc_q   <= '0;
         dram_q  <= 1'b0;
         sys_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         llc_q   <= llc_d;
         dram_q  <= dram_d;
         sys_q   <= sys_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      llc_d      = llc_q;
      lock_abort = !lock_s && (state_q inside {S_REL_DRAM, S_REL_SYS, S_RUN});
      // Aborts win over forward progress; a coincident soft request still counts one loss.
      if (lock_abort || soft_rst_req) begin
         state_d = S_ASSERT;
         cnt_d   = '0;
         if (lock_abort && (llc_q != '1)) llc_d = llc_q + LLC_ONE;
      end else begin
         case (state_q)
            S_ASSERT: begin
               if (cnt_q == HOLD_TC) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == STABLE_TC) begin
                  state_d = S_REL_DRAM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_REL_DRAM: begin
               if (cnt_q == GAP_TC) begin
                  state_d = S_REL_SYS;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_REL_SYS: begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
            S_RUN: begin
               state_d = S_RUN;
            end
            default: begin
               state_d = S_ASSERT;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Decoded from the next state so registered outputs move with the state.
   always_comb begin
      dram_d = 1'b0;
      sys_d  = 1'b0;
      done_d = 1'b0;
      case (state_d)
         S_REL_DRAM: dram_d = 1'b1;
         S_REL_SYS: begin
            dram_d = 1'b1;
            sys_d  = 1'b1;
         end
         S_RUN: begin
            dram_d = 1'b1;
            sys_d  = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign rstnn_dram      = dram_q;
   assign rstnn_system    = sys_q;
   assign seq_done        = done_q;
   assign seq_state       = state_q;
   assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_arx_conv2d_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their edge numbers,
// a monitor pops one entry whenever the DUT outputs change.
module tb_arx_conv2d_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_locked = 1'b1;
   logic       soft_rst_req = 1'b0;
   logic       rstnn_dram, rstnn_system, seq_done;
   logic [2:0] seq_state;
   logic [7:0] lock_loss_count;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   exp_t exp_q[$];

   arx_conv2d_reset_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .soft_rst_req    (soft_rst_req),
      .rstnn_dram      (rstnn_dram),
      .rstnn_system    (rstnn_system),
      .seq_done        (seq_done),
      .seq_state       (seq_state),
      .lock_loss_count (lock_loss_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pack(int st, int d, int s, int dn, int llc);
      return (st << 11) | (d << 10) | (s << 9) | (dn << 8) | llc;
   endfunction

   function automatic int dut_val();
      return pack(int'(seq_state), int'(rstnn_dram), int'(rstnn_system),
                  int'(seq_done), int'(lock_loss_count));
   endfunction

   function automatic void push(int c, int st, int d, int s, int dn, int llc);
      exp_t e;
      e.cyc = c;
      e.val = pack(st, d, s, dn, llc);
      exp_q.push_back(e);
   endfunction

   // Full release sequence after an abort (or rst release) at edge a, lock already stable.
   function automatic void push_boot(int a, int llc);
      push(a + 8,  1, 0, 0, 0, llc);
      push(a + 24, 2, 1, 0, 0, llc);
      push(a + 28, 3, 1, 1, 0, llc);
      push(a + 29, 4, 1, 1, 1, llc);
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Monitor: one pop per observed output change.
   initial begin : monitor
      int   last;
      int   cur;
      exp_t e;
      last = pack(0, 0, 0, 0, 0);
      forever begin
         @(negedge clk or posedge rst);
         #1;
         cur = dut_val();
         if (cur != last) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_change", cur, last);
            end else begin
               e = exp_q.pop_front();
               chk("output_value", cur, e.val);
               chk("change_edge", cyc, e.cyc);
            end
            last = cur;
         end
      end
   end

   initial begin : stim
      int b;
      int llc_exp;

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_rstnn_dram", int'(rstnn_dram), 0);
      chk("reset_rstnn_system", int'(rstnn_system), 0);
      chk("reset_seq_done", int'(seq_done), 0);
      chk("reset_seq_state", int'(seq_state), 0);
      chk("reset_lock_loss_count", int'(lock_loss_count), 0);

      // Nominal boot: 0 -> 1 at edge 8, DRAM at 24, system at 28, done at 29.
      b = cyc;
      push_boot(b, 0);
      rst = 1'b0;
      wait_to(b + 32);

      // Soft reset in S_RUN: resets drop next edge, count untouched, full re-run.
      b = cyc;
      push(b + 1, 0, 0, 0, 0, 0);
      push_boot(b + 1, 0);
      soft_rst_req = 1'b1;
      @(negedge clk);
      soft_rst_req = 1'b0;
      wait_to(b + 32);

      // Lock loss in S_RUN (abort 3 edges later), then unstable relock in S_WAIT_LOCK.
      b = cyc;
      push(b + 3,  0, 0, 0, 0, 1);
      push(b + 11, 1, 0, 0, 0, 1);
      push(b + 45, 2, 1, 0, 0, 1);
      push(b + 49, 3, 1, 1, 0, 1);
      push(b + 50, 4, 1, 1, 1, 1);
      pll_locked = 1'b0;
      wait_to(b + 12);
      pll_locked = 1'b1;
      wait_to(b + 24);
      pll_locked = 1'b0;
      wait_to(b + 27);
      pll_locked = 1'b1;
      wait_to(b + 52);

      // Coincident lock loss and soft request count once; soft request in S_ASSERT restarts hold.
      b = cyc;
      push(b + 3, 0, 0, 0, 0, 2);
      push_boot(b + 7, 2);
      pll_locked = 1'b0;
      wait_to(b + 2);
      soft_rst_req = 1'b1;
      wait_to(b + 3);
      soft_rst_req = 1'b0;
      pll_locked = 1'b1;
      wait_to(b + 6);
      soft_rst_req = 1'b1;
      wait_to(b + 7);
      soft_rst_req = 1'b0;
      wait_to(b + 38);

      // Async rst in S_REL_DRAM with no clock edge.
      b = cyc;
      push(b + 1,  0, 0, 0, 0, 2);
      push(b + 9,  1, 0, 0, 0, 2);
      push(b + 25, 2, 1, 0, 0, 2);
      push(b + 26, 0, 0, 0, 0, 0);
      soft_rst_req = 1'b1;
      @(negedge clk);
      soft_rst_req = 1'b0;
      wait_to(b + 26);
      #2;
      rst = 1'b1;
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);

      // Late lock: pll_locked rises at edge 40, lock_s high after 42, DRAM 16 edges later.
      b = cyc;
      push(b + 8,  1, 0, 0, 0, 0);
      push(b + 58, 2, 1, 0, 0, 0);
      push(b + 62, 3, 1, 1, 0, 0);
      push(b + 63, 4, 1, 1, 1, 0);
      rst = 1'b0;
      wait_to(b + 40);
      pll_locked = 1'b1;
      wait_to(b + 65);

      // 300 lock losses: count saturates at 255.
      llc_exp = 0;
      for (int i = 0; i < 300; i++) begin
         b = cyc;
         llc_exp = (llc_exp == 255) ? 255 : llc_exp + 1;
         push(b + 3, 0, 0, 0, 0, llc_exp);
         push_boot(b + 3, llc_exp);
         pll_locked = 1'b0;
         wait_to(b + 3);
         pll_locked = 1'b1;
         wait_to(b + 33);
      end
      chk("saturated_lock_loss_count", int'(lock_loss_count), 255);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
